// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam logic [31:0] EOF_WORD_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, start/data/stop FSM and bit timer.
module uart_rx_byte
  import uart_prog_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 347
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       byte_valid_c,
  output logic [7:0] byte_data,
  output logic       frame_err_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_meta_q, rx_s;

  assign byte_data = shift_q;

  // Two-flop synchronizer, idle-high reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s      <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Strobes are decoded from registered state so the loader can register on the sample edge
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s) byte_valid_c = 1'b1;
          else      frame_err_c  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes into little-endian words and writes
// them to instruction memory until the end-of-program marker arrives.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned ADDR_W       = 10,
  parameter logic [31:0] EOF_WORD     = EOF_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              done_o,
  output logic              frame_err_o
);

  logic        byte_valid_c, frame_err_c;
  logic [7:0]  byte_data;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d, full_word;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0] wdata_d;
  logic        we_d, done_d, ferr_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .byte_valid_c(byte_valid_c),
    .byte_data   (byte_data),
    .frame_err_c (frame_err_c)
  );

  assign full_word = {byte_data, word_q[23:0]};

  // Word assembly; after done every received byte and frame error is ignored
  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = mem_addr_o;
    wdata_d    = mem_wdata_o;
    we_d       = 1'b0;
    done_d     = done_o;
    ferr_d     = frame_err_o;
    if (mem_we_o) addr_d = mem_addr_o + ADDR_W'(1);
    if (!done_o) begin
      if (frame_err_c) ferr_d = 1'b1;
      if (byte_valid_c) begin
        word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          if (full_word == EOF_WORD) begin
            done_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            wdata_d = full_word;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q  <= '0;
      word_q      <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      done_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      mem_addr_o  <= addr_d;
      mem_wdata_o <= wdata_d;
      mem_we_o    <= we_d;
      done_o      <= done_d;
      frame_err_o <= ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench for uart_prog_loader against a byte-stream reference model.
module tb_uart_prog_loader;

  localparam int unsigned CPB    = 8;
  localparam int unsigned ADDR_W = 4;
  localparam logic [31:0] EOFW   = 32'h0000_0FFF;
  // Edges from the start-bit fall to the write strobe: 3 detect + CPB/2 + 9*CPB
  localparam int unsigned WR_LAT = 3 + CPB / 2 + 9 * CPB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_i = 1'b1;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              done_o;
  logic              frame_err_o;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W),
    .EOF_WORD    (EOFW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .done_o     (done_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: accepted bytes collect in a queue; every four make a word
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  m_bytes[$];
  int          m_addr = 0;
  bit          m_done = 0;
  bit          m_ferr = 0;

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [31:0] w;
    wr_t e;
    if (m_done) return;
    if (!stop_ok) begin
      m_ferr = 1;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_bytes.delete();
      if (w == EOFW) begin
        m_done = 1;
      end else begin
        e.addr = m_addr;
        e.data = w;
        exp_q.push_back(e);
        m_addr = (m_addr + 1) % (1 << ADDR_W);
      end
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    exp_q.delete();
    m_addr = 0;
    m_done = 0;
    m_ferr = 0;
  endtask

  // Write/done monitor: content, address, latency and pulse width
  bit prev_we = 0;
  bit prev_done = 0;
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (mem_we_o) begin
        chk("we_width", 64'(prev_we), 64'd0);
        chk("we_latency", 64'(cyc), 64'(fall_cyc + WR_LAT));
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(mem_wdata_o), 64'hX);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(mem_addr_o), 64'(e.addr));
          chk("wr_data", 64'(mem_wdata_o), 64'(e.data));
        end
      end
      if (done_o && !prev_done)
        chk("done_latency", 64'(cyc), 64'(fall_cyc + WR_LAT));
    end
    prev_we   = mem_we_o;
    prev_done = done_o;
  end

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, "_addr"}, 64'(mem_addr_o), 64'(m_addr));
    chk({tag, "_done"}, 64'(done_o), 64'(m_done));
    chk({tag, "_ferr"}, 64'(frame_err_o), 64'(m_ferr));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    model_byte(b, stop_ok);
    @(posedge clk);
    #1;
    fall_cyc = cyc;
    rx_i = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_i = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx_i = stop_ok;
    repeat (CPB) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], 1'b1, int'($urandom_range(0, 3)));
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_we", 64'(mem_we_o), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_wdata", 64'(mem_wdata_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ferr", 64'(frame_err_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [31:0] w;
    #2;
    apply_reset();

    // Two reference program words
    send_word(32'h0000_0013);
    send_word(32'h0010_0193);
    check_state("prog");

    // Short low pulse on idle line must be rejected
    @(posedge clk);
    #1 rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check_state("glitch");

    // Frame error mid-word: byte dropped, byte index kept
    send_byte(8'($urandom), 1'b1, 2);
    send_byte(8'($urandom), 1'b1, 2);
    send_byte(8'($urandom), 1'b0, 2 * CPB);
    check_state("ferr");
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h33, 1'b1, 3);
    send_byte(8'h44, 1'b1, 0);
    send_byte(8'($urandom), 1'b1, 1);
    send_byte(8'($urandom), 1'b1, 0);
    check_state("partial");

    // Random words, enough to wrap the address counter
    for (int i = 0; i < 14; i++) begin
      w = $urandom;
      if (w == EOFW) w = 32'h1234_5678;
      send_word(w);
    end
    check_state("wrap");

    // Reset in the middle of a word, then a fresh word at address 0
    send_byte(8'($urandom), 1'b1, 1);
    send_byte(8'($urandom), 1'b1, 1);
    chk("pre_reset_pending", 64'(exp_q.size()), 64'd0);
    apply_reset();
    send_word(32'hDDCC_BBAA);
    check_state("post_reset");

    // End-of-program marker, then traffic that must be ignored
    send_word(32'h0000_2083);
    send_word(EOFW);
    check_state("eof");
    send_word(32'hDEAD_BEEF);
    send_byte(8'h5A, 1'b0, 2 * CPB);
    check_state("after_done");

    repeat (4) @(posedge clk);
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
